// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of requester-side and memory-side signals for the
//                two-port memory arbiter. The slave modport is the arbiter's
//                view; the master modport is the surrounding environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    // Instruction fetch port
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_done;
    logic [15:0] i_data;
    logic        i_hit;
    logic        i_err;
    // Data memory port
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        d_hit;
    logic        d_err;
    // Shared mem_system port
    logic [15:0] m_addr;
    logic [15:0] m_data_in;
    logic        m_rd;
    logic        m_wr;
    logic [15:0] m_data_out;
    logic        m_done;
    logic        m_hit;
    logic        m_err;
    // Status
    logic        busy;

    modport slave (
        input  i_req, i_addr,
        input  d_rd, d_wr, d_addr, d_wdata,
        input  m_data_out, m_done, m_hit, m_err,
        output i_done, i_data, i_hit, i_err,
        output d_done, d_rdata, d_hit, d_err,
        output m_addr, m_data_in, m_rd, m_wr,
        output busy
    );

    modport master (
        output i_req, i_addr,
        output d_rd, d_wr, d_addr, d_wdata,
        output m_data_out, m_done, m_hit, m_err,
        input  i_done, i_data, i_hit, i_err,
        input  d_done, d_rdata, d_hit, d_err,
        input  m_addr, m_data_in, m_rd, m_wr,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one mem_system port between an instruction fetch
//                requester and a data requester. One transaction at a time,
//                round-robin on ties, hang timeout and illegal-request error.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT = 32,  // ISSUE plus WAIT cycles before a forced error
    parameter int CNT_W   = 6    // 2**CNT_W must exceed TIMEOUT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam logic c_OWN_I = 1'b0;
    localparam logic c_OWN_D = 1'b1;
    localparam logic c_OP_RD = 1'b0;
    localparam logic c_OP_WR = 1'b1;

    // The counter already holds 1 when WAIT is entered, so reaching this value
    // means ISSUE plus TIMEOUT-1 WAIT cycles have elapsed.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic             r_op;
    logic [15:0]      r_addr;
    logic [15:0]      r_wdata;
    logic [15:0]      r_rdata;
    logic             r_hit;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_req_i;
    logic             w_req_d;
    logic             w_grant_d;
    logic             w_illegal;
    logic [15:0]      w_rdata_cap;
    logic             w_mem_phase;
    logic             w_done_i;
    logic             w_done_d;

    assign w_req_i     = bus.i_req;
    assign w_req_d     = bus.d_rd | bus.d_wr;
    // Data wins when alone, or on a tie when instruction had the last grant.
    assign w_grant_d   = w_req_d & (~w_req_i | (r_last_grant == c_OWN_I));
    assign w_illegal   = bus.d_rd & bus.d_wr;
    // Writes return zero read data regardless of what mem_system drives.
    assign w_rdata_cap = (r_op == c_OP_RD) ? bus.m_data_out : 16'h0000;

    // Transaction sequencer: grant, issue, wait for Done or timeout, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_owner      <= c_OWN_I;
            r_last_grant <= c_OWN_I;
            r_op         <= c_OP_RD;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_hit        <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req_i || w_req_d) begin
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        r_hit   <= 1'b0;
                        r_err   <= 1'b0;
                        if (w_grant_d) begin
                            r_owner      <= c_OWN_D;
                            r_last_grant <= c_OWN_D;
                            r_addr       <= bus.d_addr;
                            if (w_illegal) begin
                                // Read and write together: answer with an error, never touch memory.
                                r_op    <= c_OP_RD;
                                r_wdata <= '0;
                                r_err   <= 1'b1;
                                r_state <= c_ST_RESP;
                            end else begin
                                r_op    <= bus.d_wr ? c_OP_WR : c_OP_RD;
                                r_wdata <= bus.d_wr ? bus.d_wdata : 16'h0000;
                                r_state <= c_ST_ISSUE;
                            end
                        end else begin
                            r_owner      <= c_OWN_I;
                            r_last_grant <= c_OWN_I;
                            r_addr       <= bus.i_addr;
                            r_op         <= c_OP_RD;
                            r_wdata      <= '0;
                            r_state      <= c_ST_ISSUE;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.m_done) begin
                        r_rdata <= w_rdata_cap;
                        r_hit   <= bus.m_hit;
                        r_err   <= bus.m_err;
                        r_state <= c_ST_RESP;
                    end else begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (bus.m_done) begin
                        r_rdata <= w_rdata_cap;
                        r_hit   <= bus.m_hit;
                        r_err   <= bus.m_err;
                        r_state <= c_ST_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_rdata <= '0;
                        r_hit   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign w_mem_phase = (r_state == c_ST_ISSUE) || (r_state == c_ST_WAIT);
    assign w_done_i    = (r_state == c_ST_RESP) && (r_owner == c_OWN_I);
    assign w_done_d    = (r_state == c_ST_RESP) && (r_owner == c_OWN_D);

    assign bus.m_rd      = (r_state == c_ST_ISSUE) && (r_op == c_OP_RD);
    assign bus.m_wr      = (r_state == c_ST_ISSUE) && (r_op == c_OP_WR);
    assign bus.m_addr    = w_mem_phase ? r_addr  : 16'h0000;
    assign bus.m_data_in = w_mem_phase ? r_wdata : 16'h0000;

    assign bus.i_done  = w_done_i;
    assign bus.i_data  = w_done_i ? r_rdata : 16'h0000;
    assign bus.i_hit   = w_done_i & r_hit;
    assign bus.i_err   = w_done_i & r_err;

    assign bus.d_done  = w_done_d;
    assign bus.d_rdata = w_done_d ? r_rdata : 16'h0000;
    assign bus.d_hit   = w_done_d & r_hit;
    assign bus.d_err   = w_done_d & r_err;

    assign bus.busy    = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        r_echo;
    logic [15:0] r_mem_data;
    int          checks;
    int          failures;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .TIMEOUT (32),
        .CNT_W   (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory read data: either a fixed value or an address-derived pattern.
    assign bus.m_data_out = r_echo ? (bus.m_addr ^ 16'hA5A5) : r_mem_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [72:0] all_outs();
        return {bus.i_done, bus.i_data, bus.i_hit, bus.i_err,
                bus.d_done, bus.d_rdata, bus.d_hit, bus.d_err,
                bus.m_addr, bus.m_data_in, bus.m_rd, bus.m_wr, bus.busy};
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (all_outs() !== 73'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_ifetch_hit;
        bus.i_req = 1'b1; bus.i_addr = 16'h0040;
        bus.m_done = 1'b1; bus.m_hit = 1'b1; r_mem_data = 16'h1234;
        tick();
        checks++;
        if ({bus.m_rd, bus.m_wr, bus.m_addr} !== {1'b1, 1'b0, 16'h0040}) begin
            failures++;
            $display("FAIL ifetch_issue: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=0040", bus.m_rd, bus.m_wr, bus.m_addr);
        end
        tick();
        checks++;
        if ({bus.i_done, bus.i_data, bus.i_hit, bus.i_err, bus.d_done, bus.m_rd} !== {1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL ifetch_resp: got done=%b data=%h hit=%b err=%b d_done=%b m_rd=%b expected 1 1234 1 0 0 0",
                     bus.i_done, bus.i_data, bus.i_hit, bus.i_err, bus.d_done, bus.m_rd);
        end
        bus.i_req = 1'b0; bus.m_done = 1'b0; bus.m_hit = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.i_done} !== 2'b00) begin
            failures++;
            $display("FAIL ifetch_idle: got busy=%b i_done=%b expected 0 0", bus.busy, bus.i_done);
        end
    endtask

    task automatic test_data_write_miss;
        bus.d_wr = 1'b1; bus.d_addr = 16'h0102; bus.d_wdata = 16'hBEEF;
        tick();
        checks++;
        if ({bus.m_rd, bus.m_wr, bus.m_addr, bus.m_data_in} !== {1'b0, 1'b1, 16'h0102, 16'hBEEF}) begin
            failures++;
            $display("FAIL write_issue: got rd=%b wr=%b addr=%h din=%h expected 0 1 0102 beef", bus.m_rd, bus.m_wr, bus.m_addr, bus.m_data_in);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({bus.m_wr, bus.m_addr, bus.m_data_in, bus.d_done, bus.i_done, bus.busy} !== {1'b0, 16'h0102, 16'hBEEF, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL write_wait%0d: got wr=%b addr=%h din=%h d_done=%b i_done=%b busy=%b expected 0 0102 beef 0 0 1",
                         k, bus.m_wr, bus.m_addr, bus.m_data_in, bus.d_done, bus.i_done, bus.busy);
            end
            if (k == 5) begin
                bus.m_done = 1'b1; bus.m_hit = 1'b0; r_mem_data = 16'h5555;
            end
        end
        tick();
        checks++;
        if ({bus.d_done, bus.d_rdata, bus.d_hit, bus.d_err, bus.i_done} !== {1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL write_resp: got done=%b rdata=%h hit=%b err=%b i_done=%b expected 1 0000 0 0 0",
                     bus.d_done, bus.d_rdata, bus.d_hit, bus.d_err, bus.i_done);
        end
        bus.d_wr = 1'b0; bus.m_done = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.d_done} !== 2'b00) begin
            failures++;
            $display("FAIL write_idle: got busy=%b d_done=%b expected 0 0", bus.busy, bus.d_done);
        end
    endtask

    task automatic test_tie_fairness;
        logic        exp_d;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        do_reset();
        r_echo = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        bus.d_rd  = 1'b1; bus.d_addr = 16'h0020;
        bus.m_done = 1'b1; bus.m_hit = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_d    = (n % 2 == 0);
            exp_addr = exp_d ? 16'h0020 : 16'h0010;
            exp_data = exp_d ? 16'hA585 : 16'hA5B5;
            tick();
            checks++;
            if ({bus.m_rd, bus.m_addr} !== {1'b1, exp_addr}) begin
                failures++;
                $display("FAIL tie_issue%0d: got rd=%b addr=%h expected rd=1 addr=%h", n, bus.m_rd, bus.m_addr, exp_addr);
            end
            tick();
            checks++;
            if ({bus.d_done, bus.i_done, bus.d_rdata, bus.i_data} !==
                {exp_d, ~exp_d, (exp_d ? exp_data : 16'h0000), (exp_d ? 16'h0000 : exp_data)}) begin
                failures++;
                $display("FAIL tie_resp%0d: got d_done=%b i_done=%b d_rdata=%h i_data=%h expected d_done=%b data=%h",
                         n, bus.d_done, bus.i_done, bus.d_rdata, bus.i_data, exp_d, exp_data);
            end
            if (n == 3) begin
                bus.i_req = 1'b0; bus.d_rd = 1'b0; bus.m_done = 1'b0;
            end
            tick();
            checks++;
            if (bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL tie_idle%0d: got busy=%b expected 0", n, bus.busy);
            end
        end
    endtask

    task automatic test_timeout;
        bus.d_rd = 1'b1; bus.d_addr = 16'h0200; bus.m_done = 1'b0; bus.m_hit = 1'b0;
        tick();
        checks++;
        if ({bus.m_rd, bus.m_addr} !== {1'b1, 16'h0200}) begin
            failures++;
            $display("FAIL timeout_issue: got rd=%b addr=%h expected 1 0200", bus.m_rd, bus.m_addr);
        end
        bus.i_req = 1'b1; bus.i_addr = 16'h0300;
        for (int k = 0; k < 31; k++) begin
            tick();
            checks++;
            if ({bus.d_done, bus.i_done, bus.busy} !== 3'b001) begin
                failures++;
                $display("FAIL timeout_wait%0d: got d_done=%b i_done=%b busy=%b expected 0 0 1", k, bus.d_done, bus.i_done, bus.busy);
            end
        end
        tick();
        checks++;
        if ({bus.d_done, bus.d_err, bus.d_rdata, bus.d_hit, bus.i_done} !== {1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL timeout_resp: got done=%b err=%b rdata=%h hit=%b i_done=%b expected 1 1 0000 0 0",
                     bus.d_done, bus.d_err, bus.d_rdata, bus.d_hit, bus.i_done);
        end
        bus.d_rd = 1'b0; bus.m_done = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.d_done, bus.i_done} !== 3'b000) begin
            failures++;
            $display("FAIL timeout_idle: got busy=%b d_done=%b i_done=%b expected 0 0 0", bus.busy, bus.d_done, bus.i_done);
        end
        tick();
        checks++;
        if ({bus.m_rd, bus.m_addr} !== {1'b1, 16'h0300}) begin
            failures++;
            $display("FAIL pending_issue: got rd=%b addr=%h expected 1 0300", bus.m_rd, bus.m_addr);
        end
        tick();
        checks++;
        if ({bus.i_done, bus.i_data, bus.i_err} !== {1'b1, 16'hA6A5, 1'b0}) begin
            failures++;
            $display("FAIL pending_resp: got done=%b data=%h err=%b expected 1 a6a5 0", bus.i_done, bus.i_data, bus.i_err);
        end
        bus.i_req = 1'b0; bus.m_done = 1'b0;
        tick();
    endtask

    task automatic test_illegal;
        bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0400; bus.d_wdata = 16'h1111;
        tick();
        checks++;
        if ({bus.m_rd, bus.m_wr, bus.d_done, bus.d_err, bus.d_rdata, bus.d_hit} !== {1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL illegal_resp: got rd=%b wr=%b done=%b err=%b rdata=%h hit=%b expected 0 0 1 1 0000 0",
                     bus.m_rd, bus.m_wr, bus.d_done, bus.d_err, bus.d_rdata, bus.d_hit);
        end
        bus.d_rd = 1'b0; bus.d_wr = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.d_done, bus.m_rd, bus.m_wr} !== 4'b0000) begin
            failures++;
            $display("FAIL illegal_idle: got busy=%b done=%b rd=%b wr=%b expected 0 0 0 0", bus.busy, bus.d_done, bus.m_rd, bus.m_wr);
        end
    endtask

    task automatic test_reset_mid_op;
        bus.d_rd = 1'b1; bus.d_addr = 16'h0500; bus.m_done = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.m_addr} !== {1'b1, 16'h0500}) begin
            failures++;
            $display("FAIL midop_wait: got busy=%b addr=%h expected 1 0500", bus.busy, bus.m_addr);
        end
        rst = 1'b1; bus.d_rd = 1'b0;
        tick();
        checks++;
        if (all_outs() !== 73'h0) begin
            failures++;
            $display("FAIL midop_reset: got %h expected 0", all_outs());
        end
        rst = 1'b0; bus.m_done = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (all_outs() !== 73'h0) begin
                failures++;
                $display("FAIL midop_stray%0d: got %h expected 0", k, all_outs());
            end
        end
        bus.i_req = 1'b1; bus.i_addr = 16'h0600; bus.d_rd = 1'b1; bus.d_addr = 16'h0500;
        tick();
        checks++;
        if ({bus.m_rd, bus.m_addr} !== {1'b1, 16'h0500}) begin
            failures++;
            $display("FAIL midop_first_grant: got rd=%b addr=%h expected 1 0500", bus.m_rd, bus.m_addr);
        end
        tick();
        checks++;
        if ({bus.d_done, bus.d_rdata, bus.i_done} !== {1'b1, 16'hA0A5, 1'b0}) begin
            failures++;
            $display("FAIL midop_resp: got d_done=%b rdata=%h i_done=%b expected 1 a0a5 0", bus.d_done, bus.d_rdata, bus.i_done);
        end
        bus.i_req = 1'b0; bus.d_rd = 1'b0; bus.m_done = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        r_echo = 1'b0;
        r_mem_data = 16'h0000;
        bus.i_req = 1'b0; bus.i_addr = 16'h0000;
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 16'h0000; bus.d_wdata = 16'h0000;
        bus.m_done = 1'b0; bus.m_hit = 1'b0; bus.m_err = 1'b0;
        test_reset();
        test_ifetch_hit();
        test_data_write_miss();
        test_tie_fairness();
        test_timeout();
        test_illegal();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
